// File: rtl/sdram_writer.sv
`default_nettype none
// ============================================================================
// Module   : sdram_writer
// Purpose  : Avalon-MM burst write master that streams 64-bit pixel words into
//            the SDRAM frame buffer through a show-ahead FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_writer #(
    parameter int          SDRAM_DATA_WIDTH = 64,
    parameter logic [28:0] BASE_ADDR        = 29'h400_0000,
    parameter logic [31:0] FRAME_WORDS      = 32'hFD200,
    parameter int          BURST_LEN        = 8,
    parameter int          FIFO_DEPTH       = 32
) (
    input  logic                          sdram_clk,
    input  logic                          rst,
    input  logic                          enable_i,
    input  logic [SDRAM_DATA_WIDTH-1:0]   pixel_data_i,
    input  logic                          pixel_valid_i,
    output logic                          pixel_ready_o,
    output logic [28:0]                   sdram_address_o,
    output logic [7:0]                    sdram_burstcount_o,
    input  logic                          sdram_waitrequest_i,
    output logic [SDRAM_DATA_WIDTH-1:0]   sdram_writedata_o,
    output logic [SDRAM_DATA_WIDTH/8-1:0] sdram_byteenable_o,
    output logic                          sdram_write_o,
    output logic                          frame_done_o,
    output logic                          frame_ready_o
);

    localparam int                 c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W     = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_BURST_CNT = c_CNT_W'(BURST_LEN);
    localparam logic [7:0]         c_LAST_BEAT = 8'(BURST_LEN - 1);
    localparam logic [28:0]        c_LAST_BURST_ADDR =
        BASE_ADDR + FRAME_WORDS[28:0] - 29'(BURST_LEN);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;

    logic [SDRAM_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]          r_wr_ptr;
    logic [c_PTR_W-1:0]          r_rd_ptr;
    logic [c_CNT_W-1:0]          r_count;
    logic                        r_ready_en;
    logic [7:0]                  r_beat;
    logic [28:0]                 r_addr;
    logic                        r_frame_done;
    logic                        r_frame_ready;

    logic                        w_full;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_last_beat;

    // Ready is held low through reset and rises on the first clock after it.
    assign w_full        = (r_count == c_FULL);
    assign pixel_ready_o = r_ready_en & ~w_full;
    assign w_push        = pixel_valid_i & pixel_ready_o;
    assign w_pop         = sdram_write_o & ~sdram_waitrequest_i;
    assign w_last_beat   = w_pop & (r_beat == c_LAST_BEAT);

    assign sdram_write_o      = (r_state == S_BURST);
    assign sdram_address_o    = r_addr;
    assign sdram_burstcount_o = 8'(BURST_LEN);
    assign sdram_writedata_o  = r_mem[r_rd_ptr];
    assign sdram_byteenable_o = '1;
    assign frame_done_o       = r_frame_done;
    assign frame_ready_o      = r_frame_ready;

    always_ff @(posedge sdram_clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A burst starts only with a full burst buffered, so write never gaps.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable_i && (r_count >= c_BURST_CNT)) begin
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if (w_last_beat) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sdram_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= pixel_data_i;
        end
    end

    always_ff @(posedge sdram_clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_ready_en    <= 1'b0;
            r_beat        <= '0;
            r_addr        <= BASE_ADDR;
            r_frame_done  <= 1'b0;
            r_frame_ready <= 1'b0;
        end else begin
            r_ready_en   <= 1'b1;
            r_frame_done <= 1'b0;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                r_beat   <= w_last_beat ? 8'd0 : r_beat + 8'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_last_beat) begin
                if (r_addr == c_LAST_BURST_ADDR) begin
                    r_addr        <= BASE_ADDR;
                    r_frame_done  <= 1'b1;
                    r_frame_ready <= 1'b1;
                end else begin
                    r_addr <= r_addr + 29'(BURST_LEN);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/sdram_writer.md
Name: sdram_writer

Overview:
Avalon-MM burst write master that stores an incoming 64-bit pixel-word stream into the SDRAM frame buffer. Words enter through a valid/ready port and are buffered in an internal show-ahead FIFO. Fixed-length bursts are issued to sequential word addresses across one 1080p frame, and the address wraps to the buffer base at the frame end. The block flags frame completion so the SDRAM read path can start fetching.

Parameters:
SDRAM_DATA_WIDTH, 64, data bus width in bits; byteenable width is SDRAM_DATA_WIDTH/8
BASE_ADDR, 29'h400_0000, Avalon word address of frame buffer 0 (byte address 0x2000_0000)
FRAME_WORDS, 32'hFD200, words per frame (1920x1080x32 bit / 64); must be a multiple of BURST_LEN
BURST_LEN, 8, beats per write burst, range 1..128
FIFO_DEPTH, 32, internal FIFO depth; power of two, at least 2*BURST_LEN

Ports:
sdram_clk  in  1  sole clock
rst  in  1  asynchronous, active-high reset
enable_i  in  1  permits new bursts to start
pixel_data_i  in  SDRAM_DATA_WIDTH  input word
pixel_valid_i  in  1  input word valid
pixel_ready_o  out  1  FIFO can accept a word
sdram_address_o  out  29  Avalon word address, held for the whole burst
sdram_burstcount_o  out  8  burst length
sdram_waitrequest_i  in  1  slave stall
sdram_writedata_o  out  SDRAM_DATA_WIDTH  write data
sdram_byteenable_o  out  SDRAM_DATA_WIDTH/8  all ones, constant
sdram_write_o  out  1  write request
frame_done_o  out  1  one-cycle pulse after the final beat of a frame
frame_ready_o  out  1  sticky; set after the first complete frame

Behaviour:
- Reset values: pixel_ready_o=0 during reset; sdram_write_o=0; sdram_address_o=BASE_ADDR; sdram_burstcount_o=BURST_LEN; frame_done_o=0; frame_ready_o=0; FIFO empty; state IDLE; beat counter 0.
- Reset is asynchronous. Asserting it mid-burst aborts the burst immediately. This protocol violation is accepted only at system reset.
- Input handshake: a word is pushed when pixel_valid_i and pixel_ready_o. pixel_ready_o = ~fifo_full, derived from registered count; no combinational path from the input.
- FIFO count is updated for simultaneous push and pop: both in one cycle leaves the count unchanged. A full FIFO with a pop does not accept the push in that cycle.
- sdram_writedata_o always equals the FIFO head word (show-ahead).
- A beat is accepted when sdram_write_o and ~sdram_waitrequest_i.
- FSM IDLE: when enable_i and fifo_count >= BURST_LEN, next cycle sdram_write_o=1 and state=BURST. The address holds its current value. A burst never starts without BURST_LEN words buffered, so sdram_write_o never drops mid-burst.
- FSM BURST: each accepted beat pops the FIFO and increments the beat counter. While waitrequest is high, address, data, burstcount and write hold.
- On acceptance of beat BURST_LEN-1: sdram_write_o=0 next cycle and the state returns to IDLE. Address advances by BURST_LEN. If the burst just written started at BASE_ADDR+FRAME_WORDS-BURST_LEN, the address wraps to BASE_ADDR instead, frame_done_o pulses for one cycle, and frame_ready_o sets and stays set until reset.
- There is at least one IDLE cycle between bursts.
- enable_i deasserted mid-burst: the current burst completes; no new burst starts. The address is retained, so writing resumes at the same point when enable_i returns.
- Address arithmetic is 29-bit unsigned. The wrap compare is exact equality on the burst start address.

Test Plan:
- Reset: hold rst with random inputs -> sdram_write_o=0, sdram_address_o=0x4000000, frame_ready_o=0, pixel_ready_o=0; release rst -> pixel_ready_o=1 the next cycle.
- Single burst, enable_i=1, waitrequest=0: push words 0..7 -> one burst of 8 consecutive write cycles at address 0x4000000, burstcount 8, data 0..7 in order, byteenable 0xFF. The next burst uses address 0x4000008.
- Waitrequest stall: assert waitrequest on beats 0 and 3 for 3 cycles each -> address, data and write are held; all 8 words are written exactly once, in order.
- Backpressure: enable_i=0 with continuous valid -> exactly 32 words accepted, then pixel_ready_o=0. Set enable_i=1 -> four 8-beat bursts drain the FIFO; pixel_ready_o reasserts after the first pop.
- Frame wrap with FRAME_WORDS=16, BURST_LEN=8: stream 40 words -> bursts at base, base+8, base, base+8, base. frame_done_o pulses twice. frame_ready_o rises after beat 15 and stays high.
- Mid-operation: deassert enable_i during beat 2 -> the burst finishes all 8 beats, then no write. Assert rst mid-burst -> sdram_write_o=0 immediately and the address returns to 0x4000000.
